// File: rtl/diff_rx_pkg.sv
// rtl/diff_rx_pkg.sv - shared types and constants for the TDC difference receiver
package diff_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW       = 2'd1,
    WAIT_HIGH = 2'd2
  } rx_state_t;

  localparam int DW_DEFAULT = 20;
  // Nominal low width of one strobe from the pair-difference stage.
  localparam int STROBE_LEN = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-based result FIFO with level count and head output
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  // A pop frees a slot first, so a push into a full FIFO with a pop in the same cycle succeeds.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok) level <= level + 1'b1;
      else if (pop_ok && !push_ok) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/diff_sample_rx.sv
// rtl/diff_sample_rx.sv - strobe validation, averaging and result queue for the TDC difference stream
module diff_sample_rx
  import diff_rx_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int AVG_LOG2   = 2,
  parameter int MIN_LOW    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 i_data,
  input  logic                          dval_n,
  input  logic                          clr,
  output logic [DW-1:0]                 o_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic                          err_short,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int              AW         = DW + AVG_LOG2;
  localparam int              CW         = AVG_LOG2 + 1;
  localparam logic [CW-1:0]   CNT_FULL   = CW'(1 << AVG_LOG2);
  localparam logic [4:0]      LOW_TARGET = 5'(MIN_LOW);

  rx_state_t            state;
  rx_state_t            next_state;
  logic                 prev_n;
  logic                 armed;
  logic                 fall;
  logic [4:0]           low_cnt;
  logic [4:0]           low_cnt_nxt;
  logic [DW-1:0]        hold;
  logic                 load_hold;
  logic                 commit;
  logic                 short_err;
  logic [DW-1:0]        commit_data;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic [DW-1:0]        result;
  logic                 push_pend;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  // Edge needs dval_n seen high since reset, so a strobe already low at release is ignored.
  assign fall    = armed && prev_n && !dval_n;
  assign o_valid = !fifo_empty;
  assign pop     = o_valid && o_ready;
  assign sum     = acc + AW'($signed(commit_data));
  assign cnt_nxt = cnt + 1'b1;

  // Strobe history and arming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_n <= 1'b1;
      armed  <= 1'b0;
    end else begin
      prev_n <= dval_n;
      if (dval_n) armed <= 1'b1;
    end
  end

  // Strobe FSM state, low-width counter and captured word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      low_cnt <= '0;
      hold    <= '0;
    end else begin
      state   <= next_state;
      low_cnt <= low_cnt_nxt;
      if (load_hold) hold <= i_data;
    end
  end

  // Strobe FSM: qualify the low width, commit once per strobe, flag short strobes.
  always_comb begin
    next_state  = state;
    low_cnt_nxt = low_cnt;
    load_hold   = 1'b0;
    commit      = 1'b0;
    short_err   = 1'b0;
    commit_data = hold;
    case (state)
      IDLE: begin
        if (fall) begin
          load_hold   = 1'b1;
          low_cnt_nxt = 5'd1;
          if (LOW_TARGET == 5'd1) begin
            commit      = 1'b1;
            commit_data = i_data;
            next_state  = WAIT_HIGH;
          end else begin
            next_state = LOW;
          end
        end
      end
      LOW: begin
        if (dval_n) begin
          short_err  = 1'b1;
          next_state = IDLE;
        end else begin
          low_cnt_nxt = low_cnt + 5'd1;
          if (low_cnt_nxt == LOW_TARGET) begin
            commit     = 1'b1;
            next_state = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (dval_n) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Accumulate committed words; the completing word closes the average and queues a push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      push_pend <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (commit) begin
        if (cnt_nxt == CNT_FULL) begin
          result    <= DW'(sum >>> AVG_LOG2);
          push_pend <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt_nxt;
        end
      end
    end
  end

  // Sticky error and overflow flags; clr wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_short <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      err_short <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (short_err) err_short <= 1'b1;
      if (push_pend && fifo_full && !pop) ovf <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_pend),
    .pop   (pop),
    .din   (result),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level),
    .head  (o_data)
  );

endmodule
